// File: rtl/ws2812b_driver.sv
// ws2812b_driver: drives a WS2812B chain, sending one captured colour to
// NUM_LEDS LEDs per frame (G,R,B order, MSB first), followed by a latch gap.
// Optional feature: define WS2812B_PENDING_EN to queue one request that
// arrives while a frame is in progress.
module ws2812b_driver #(
  parameter int NUM_LEDS     = 8,
  parameter int T0H_CYCLES   = 11,
  parameter int T1H_CYCLES   = 22,
  parameter int BIT_CYCLES   = 34,
  parameter int RESET_CYCLES = 8100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_send,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  output logic       o_data,
  output logic       o_busy,
  output logic       o_done
);

  // One counter serves both the bit period and the latch gap.
  localparam int CNT_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CW-1:0] T0H_M1  = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1H_M1  = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] RST_M1  = CW'(RESET_CYCLES - 1);
  localparam logic [LW-1:0] LED_M1  = LW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t        state, state_nxt;
  logic [23:0]   col_q;      // colour captured at accept, reloaded per LED
  logic [23:0]   shreg;      // bit being sent is shreg[23]
  logic [4:0]    bit_cnt;
  logic [LW-1:0] led_cnt;
  logic [CW-1:0] cyc_cnt;
  logic          done_q;

  logic          start;
  logic [23:0]   start_col;
  logic          hi_end, bit_end, last_bit, last_led, latch_end;

`ifdef WS2812B_PENDING_EN
  logic          pend_vld;
  logic [23:0]   pend_col;

  // A fresh request in IDLE wins over an older pending one.
  assign start     = (state == IDLE) && (i_send || pend_vld);
  assign start_col = i_send ? {i_green, i_red, i_blue} : pend_col;

  // One-deep pending slot: latest busy-time request overwrites, start consumes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend_vld <= 1'b0;
      pend_col <= '0;
    end else if ((state != IDLE) && i_send) begin
      pend_vld <= 1'b1;
      pend_col <= {i_green, i_red, i_blue};
    end else if (start) begin
      pend_vld <= 1'b0;
    end
  end
`else
  assign start     = (state == IDLE) && i_send;
  assign start_col = {i_green, i_red, i_blue};
`endif

  assign hi_end    = cyc_cnt == (shreg[23] ? T1H_M1 : T0H_M1);
  assign bit_end   = cyc_cnt == BIT_M1;
  assign last_bit  = bit_cnt == 5'd23;
  assign last_led  = led_cnt == LED_M1;
  assign latch_end = cyc_cnt == RST_M1;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start)     state_nxt = HIGH;
      HIGH:  if (hi_end)    state_nxt = LOW;
      LOW:   if (bit_end)   state_nxt = (last_bit && last_led) ? LATCH : HIGH;
      LATCH: if (latch_end) state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, bit timing, shift/reload, LED count, done flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      led_cnt <= '0;
      cyc_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == LATCH) && latch_end;
      unique case (state)
        IDLE: if (start) begin
          col_q   <= start_col;
          shreg   <= start_col;
          bit_cnt <= '0;
          led_cnt <= '0;
          cyc_cnt <= '0;
        end
        HIGH: cyc_cnt <= cyc_cnt + CW'(1);
        LOW: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (last_bit) begin
              // Reload on the LED boundary so the next LED follows without a gap.
              bit_cnt <= '0;
              shreg   <= col_q;
              led_cnt <= last_led ? '0 : led_cnt + LW'(1);
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              shreg   <= {shreg[22:0], 1'b0};
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        LATCH: cyc_cnt <= latch_end ? '0 : cyc_cnt + CW'(1);
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    o_data = (state == HIGH);
    o_busy = (state != IDLE);
    o_done = done_q;
  end

endmodule

// File: tb/tb_ws2812b_driver.sv
// Scoreboard bench for ws2812b_driver: stimulus pushes per-bit high times and
// frame lengths; a monitor decodes the serial line and pops/compares.
module tb_ws2812b_driver;

  localparam int NL = 2, T0H = 2, T1H = 4, BITC = 6, RSTC = 10;
  localparam int FRAME_LEN = NL * 24 * BITC + RSTC;   // 298

  logic clk = 1'b0;
  logic rst_n, send;
  logic [7:0] red, green, blue;
  logic data, busy, done;

  int checks = 0, failures = 0;
  int exp_bits[$];
  int exp_frames[$];

  ws2812b_driver #(
    .NUM_LEDS(NL), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .BIT_CYCLES(BITC), .RESET_CYCLES(RSTC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_send(send),
    .i_red(red), .i_green(green), .i_blue(blue),
    .o_data(data), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    logic [23:0] c;
    c = {g, r, b};
    for (int l = 0; l < NL; l++)
      for (int i = 23; i >= 0; i--)
        exp_bits.push_back(c[i] ? T1H : T0H);
    exp_frames.push_back(FRAME_LEN);
  endtask

  task automatic do_send(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                         input bit expect_frame);
    @(posedge clk); #1;
    if (expect_frame) push_frame(g, r, b);
    green = g; red = r; blue = b; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    green = 8'($urandom); red = 8'($urandom); blue = 8'($urandom);
  endtask

  task automatic wait_done(input int limit, input bit wiggle, output bit got);
    got = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (wiggle) red = 8'($urandom);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(got), 1);
  endtask

  // Monitor: decode high/low runs, check against the scoreboard.
  int hi = 0, lo = 0, prev_hi = 0, busy_cnt = 0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hi = 0; lo = 0; busy_cnt = 0; prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (data) begin
        if (hi == 0) begin
          if (lo > 0) chk("bit_low", lo, BITC - prev_hi);
          lo = 0;
        end
        hi++;
        chk("data_implies_busy", int'(busy), 1);
      end else begin
        if (hi > 0) begin
          if (exp_bits.size() == 0) chk("unexpected_bit", hi, 0);
          else chk("bit_high", hi, exp_bits.pop_front());
          prev_hi = hi;
          hi = 0;
        end
        if (busy) lo++;
      end
      if (done) begin
        if (exp_frames.size() == 0) chk("unexpected_done", 1, 0);
        else chk("frame_len", busy_cnt, exp_frames.pop_front());
        chk("done_width", int'(prev_done), 0);
        busy_cnt = 0;
        lo = 0;
      end
      prev_done = done;
    end
  end

  initial begin
    bit got;
    rst_n = 1'b0; send = 1'b1;
    green = 8'hFF; red = 8'hFF; blue = 8'hFF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; send = 1'b0;
    @(negedge clk);
    chk("rst_data", int'(data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    chk("send_in_reset_dropped", int'(busy), 0);

    // G=FF: 8 long bits then 16 short bits per LED
    do_send(8'hFF, 8'h00, 8'h00, 1'b1);
    wait_done(400, 1'b0, got);

    // G=80 R=01: first and 16th bit of each LED long
    do_send(8'h80, 8'h01, 8'h00, 1'b1);
    wait_done(400, 1'b0, got);

    // Colour inputs toggled throughout the frame must not matter
    do_send(8'hFF, 8'h00, 8'h00, 1'b1);
    wait_done(400, 1'b1, got);

    // Reset in bit 30: abort, no done, then a normal frame
    do_send(8'h12, 8'h34, 8'h56, 1'b1);
    repeat (30 * BITC) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_data", int'(data), 0);
    chk("abort_busy", int'(busy), 0);
    exp_bits.delete();
    exp_frames.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    do_send(8'h00, 8'h00, 8'hAA, 1'b1);
    wait_done(400, 1'b0, got);

    // Send coincident with done: next frame with no idle gap
    do_send(8'h0F, 8'hF0, 8'h3C, 1'b1);
    wait_done(400, 1'b0, got);
    if (got) begin
      push_frame(8'hC3, 8'h5A, 8'h81);
      green = 8'hC3; red = 8'h5A; blue = 8'h81; send = 1'b1;
      @(posedge clk); #1 send = 1'b0;
      @(negedge clk);
      chk("b2b_data", int'(data), 1);
      chk("b2b_busy", int'(busy), 1);
      wait_done(400, 1'b0, got);
    end

`ifdef WS2812B_PENDING_EN
    // Two busy-time requests: only the later (B=22) runs, right after done
    do_send(8'h00, 8'h00, 8'h00, 1'b1);
    repeat (50) @(posedge clk);
    do_send(8'h00, 8'h00, 8'h11, 1'b0);
    repeat (50) @(posedge clk);
    do_send(8'h00, 8'h00, 8'h22, 1'b1);
    wait_done(400, 1'b0, got);
    @(negedge clk);
    chk("pend_start_data", int'(data), 1);
    wait_done(400, 1'b0, got);
`else
    // Busy-time request is dropped: exactly one frame
    do_send(8'h55, 8'hAA, 8'h00, 1'b1);
    repeat (97) @(posedge clk);
    do_send(8'hFF, 8'hFF, 8'hFF, 1'b0);
    wait_done(400, 1'b0, got);
    repeat (320) @(negedge clk);
    chk("no_second_frame", int'(busy), 0);
`endif

    repeat (20) @(negedge clk);
    chk("bits_left", exp_bits.size(), 0);
    chk("frames_left", exp_frames.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
